// File: rtl/branch_control_unit_if.sv
// Bundles the branch-decision signals of branch_control_unit so a
// datapath or a bench can carry them as one object.
// master: the side that drives the opcode, flag and qualifiers.
// slave:  the branch control unit view of the same signals.
interface branch_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       branchop;
    logic             zero;
    logic             out;
    logic             valid;
    logic             stats_clr;
    logic             taken_q;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output branchop,
        output zero,
        output valid,
        output stats_clr,
        input  out,
        input  taken_q,
        input  branch_cnt,
        input  taken_cnt
    );

    modport slave (
        input  branchop,
        input  zero,
        input  valid,
        input  stats_clr,
        output out,
        output taken_q,
        output branch_cnt,
        output taken_cnt
    );
endinterface

// File: rtl/branch_control_unit.sv
// Branch-decision block of the MIPS datapath.
// Combines the 2-bit branch opcode with the ALU zero flag to produce the
// PC-source select, keeps a registered copy of the decision, and optionally
// keeps saturating branch statistics.
// Optional feature macro: BRANCH_CONTROL_STATS_EN (enables the counters;
// when undefined the counters read as constant 0 and stats_clr is ignored).
// The port list keeps branchop, zero, out first so that the legacy
// three-port positional instantiation (branchop, zero, out) still works.
module branch_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic [1:0]       branchop,
    input  logic             zero,
    output logic             out,
    input  logic             clk,
    input  logic             rst,
    input  logic             valid = 1'b1,
    input  logic             stats_clr = 1'b0,
    output logic             taken_q,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    logic taken_d;

    // Decode the opcode into the PC-source select; depends only on branchop and zero.
    always_comb begin
        out = 1'b0;
        case (branchop)
            2'b00:   out = 1'b0;
            2'b01:   out = zero;
            2'b10:   out = ~zero;
            2'b11:   out = 1'b1;
            default: out = 1'b0;
        endcase
    end

    // Only qualified instructions leave a taken decision in the register.
    always_comb begin
        taken_d = out & valid;
    end

    // Registered copy of the decision for later pipeline stages and debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q <= 1'b0;
        end else begin
            taken_q <= taken_d;
        end
    end

`ifdef BRANCH_CONTROL_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] branchCnt_q;
    logic [CNT_W-1:0] branchCnt_d;
    logic [CNT_W-1:0] takenCnt_q;
    logic [CNT_W-1:0] takenCnt_d;

    // Next counter values: clear wins over counting, and both counters stick
    // at all-ones. A taken branch is always a branch-class op, and both
    // counters share the same ceiling, so takenCnt never overtakes branchCnt.
    always_comb begin
        branchCnt_d = branchCnt_q;
        takenCnt_d  = takenCnt_q;
        if (stats_clr) begin
            branchCnt_d = '0;
            takenCnt_d  = '0;
        end else if (valid) begin
            if ((branchop != 2'b00) && (branchCnt_q != CNT_MAX)) begin
                branchCnt_d = branchCnt_q + CNT_ONE;
            end
            if (out && (takenCnt_q != CNT_MAX)) begin
                takenCnt_d = takenCnt_q + CNT_ONE;
            end
        end
    end

    // Counter registers; reset discards any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            branchCnt_q <= '0;
            takenCnt_q  <= '0;
        end else begin
            branchCnt_q <= branchCnt_d;
            takenCnt_q  <= takenCnt_d;
        end
    end

    assign branch_cnt = branchCnt_q;
    assign taken_cnt  = takenCnt_q;
`else
    logic unused_stats_clr;

    // Statistics are compiled out: counters read as zero and the clear is ignored.
    assign branch_cnt       = '0;
    assign taken_cnt        = '0;
    assign unused_stats_clr = stats_clr;
`endif

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed self-checking bench for branch_control_unit.
// Two instances: the default CNT_W=16 unit and a CNT_W=2 unit used to reach
// saturation quickly. Expected counter values follow the build's
// BRANCH_CONTROL_STATS_EN setting (zero when the counters are compiled out).
module tb_branch_control_unit;

`ifdef BRANCH_CONTROL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    branch_control_unit_if #(.CNT_W(16)) mainIf ();
    branch_control_unit_if #(.CNT_W(2))  satIf ();

    branch_control_unit #(.CNT_W(16)) dutMain (
        .branchop   (mainIf.branchop),
        .zero       (mainIf.zero),
        .out        (mainIf.out),
        .clk        (clk),
        .rst        (rst),
        .valid      (mainIf.valid),
        .stats_clr  (mainIf.stats_clr),
        .taken_q    (mainIf.taken_q),
        .branch_cnt (mainIf.branch_cnt),
        .taken_cnt  (mainIf.taken_cnt)
    );

    branch_control_unit #(.CNT_W(2)) dutSat (
        .branchop   (satIf.branchop),
        .zero       (satIf.zero),
        .out        (satIf.out),
        .clk        (clk),
        .rst        (rst),
        .valid      (satIf.valid),
        .stats_clr  (satIf.stats_clr),
        .taken_q    (satIf.taken_q),
        .branch_cnt (satIf.branch_cnt),
        .taken_cnt  (satIf.taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the same instruction into both instances.
    task automatic applyStimulus(input logic [1:0] bop, input logic z,
                                 input logic v, input logic clr);
        mainIf.branchop  = bop;
        mainIf.zero      = z;
        mainIf.valid     = v;
        mainIf.stats_clr = clr;
        satIf.branchop   = bop;
        satIf.zero       = z;
        satIf.valid      = v;
        satIf.stats_clr  = clr;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_truth_table();
        logic [1:0] bops [8];
        logic       zs   [8];
        logic       exps [8];
        bops = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11};
        zs   = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
        exps = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(bops[i], zs[i], 1'b0, 1'b0);
            #5;
            vectors++;
            if (mainIf.out !== exps[i]) begin
                miscompares++;
                $display("[TB] FAIL truth_table bop=%b z=%b out=%b expected=%b",
                         bops[i], zs[i], mainIf.out, exps[i]);
            end
        end
    endtask

    task automatic test_reset();
        applyStimulus(2'b11, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stepEdge();
            vectors++;
            if (mainIf.taken_q !== 1'b0 || mainIf.branch_cnt !== 16'd0 ||
                mainIf.taken_cnt !== 16'd0 || satIf.branch_cnt !== 2'd0 ||
                satIf.taken_cnt !== 2'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_state taken_q=%b bcnt=%0d tcnt=%0d sat=%0d/%0d expected all 0",
                         mainIf.taken_q, mainIf.branch_cnt, mainIf.taken_cnt,
                         satIf.branch_cnt, satIf.taken_cnt);
            end
            vectors++;
            if (mainIf.out !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL reset_out out=%b expected=1", mainIf.out);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_registered();
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0);
        stepEdge();
        vectors++;
        if (mainIf.taken_q !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL registered_taken taken_q=%b expected=1", mainIf.taken_q);
        end
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        stepEdge();
        vectors++;
        if (mainIf.taken_q !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL registered_invalid taken_q=%b expected=0", mainIf.taken_q);
        end
    endtask

    task automatic test_stats();
        logic [1:0]  bops  [4];
        logic        zs    [4];
        logic        tq    [4];
        logic [15:0] bexp  [4];
        logic [15:0] texp  [4];
        logic [15:0] b;
        logic [15:0] t;
        bops = '{2'b01, 2'b10, 2'b00, 2'b11};
        zs   = '{1'b1,  1'b1,  1'b0,  1'b0};
        tq   = '{1'b1,  1'b0,  1'b0,  1'b1};
        bexp = '{16'd1, 16'd2, 16'd2, 16'd3};
        texp = '{16'd1, 16'd1, 16'd1, 16'd2};
        rst = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        stepEdge();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bops[i], zs[i], 1'b1, 1'b0);
            stepEdge();
            b = STATS ? bexp[i] : 16'd0;
            t = STATS ? texp[i] : 16'd0;
            vectors++;
            if (mainIf.taken_q !== tq[i] || mainIf.branch_cnt !== b ||
                mainIf.taken_cnt !== t) begin
                miscompares++;
                $display("[TB] FAIL stats_step%0d taken_q=%b bcnt=%0d tcnt=%0d expected %b/%0d/%0d",
                         i, mainIf.taken_q, mainIf.branch_cnt, mainIf.taken_cnt, tq[i], b, t);
            end
        end
        // Unqualified taken branch: no register or counter change.
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
        stepEdge();
        b = STATS ? 16'd3 : 16'd0;
        t = STATS ? 16'd2 : 16'd0;
        vectors++;
        if (mainIf.out !== 1'b1 || mainIf.taken_q !== 1'b0 ||
            mainIf.branch_cnt !== b || mainIf.taken_cnt !== t) begin
            miscompares++;
            $display("[TB] FAIL stats_invalid out=%b taken_q=%b bcnt=%0d tcnt=%0d expected 1/0/%0d/%0d",
                     mainIf.out, mainIf.taken_q, mainIf.branch_cnt, mainIf.taken_cnt, b, t);
        end
        // Clear beats a coincident increment and leaves taken_q alone.
        applyStimulus(2'b11, 1'b0, 1'b1, 1'b1);
        stepEdge();
        vectors++;
        if (mainIf.taken_q !== 1'b1 || mainIf.branch_cnt !== 16'd0 ||
            mainIf.taken_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL stats_clear taken_q=%b bcnt=%0d tcnt=%0d expected 1/0/0",
                     mainIf.taken_q, mainIf.branch_cnt, mainIf.taken_cnt);
        end
        applyStimulus(2'b11, 1'b0, 1'b1, 1'b0);
        stepEdge();
        b = STATS ? 16'd1 : 16'd0;
        vectors++;
        if (mainIf.branch_cnt !== b || mainIf.taken_cnt !== b) begin
            miscompares++;
            $display("[TB] FAIL stats_after_clear bcnt=%0d tcnt=%0d expected %0d/%0d",
                     mainIf.branch_cnt, mainIf.taken_cnt, b, b);
        end
        // Mid-stream reset discards the coincident increment.
        rst = 1'b1;
        stepEdge();
        rst = 1'b0;
        vectors++;
        if (mainIf.taken_q !== 1'b0 || mainIf.branch_cnt !== 16'd0 ||
            mainIf.taken_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL midstream_reset taken_q=%b bcnt=%0d tcnt=%0d expected 0/0/0",
                     mainIf.taken_q, mainIf.branch_cnt, mainIf.taken_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] sexp [5];
        logic [1:0] e;
        sexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        stepEdge();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b11, 1'b0, 1'b1, 1'b0);
            stepEdge();
            e = STATS ? sexp[i] : 2'd0;
            vectors++;
            if (satIf.branch_cnt !== e || satIf.taken_cnt !== e || satIf.taken_q !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL saturation_step%0d bcnt=%0d tcnt=%0d taken_q=%b expected %0d/%0d/1",
                         i, satIf.branch_cnt, satIf.taken_cnt, satIf.taken_q, e, e);
            end
        end
        // Untaken branches at saturation keep taken_cnt within branch_cnt.
        applyStimulus(2'b01, 1'b0, 1'b1, 1'b0);
        stepEdge();
        e = STATS ? 2'd3 : 2'd0;
        vectors++;
        if (satIf.branch_cnt !== e || satIf.taken_cnt !== e || satIf.taken_q !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL saturation_hold bcnt=%0d tcnt=%0d taken_q=%b expected %0d/%0d/0",
                     satIf.branch_cnt, satIf.taken_cnt, satIf.taken_q, e, e);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        test_truth_table();
        test_reset();
        test_registered();
        test_stats();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
